map_tile_ram: RTL and testbench

MAP_TILE_RAM -- requirements
Module: map_tile_ram

---
 rtl/map_tile_ram.sv | 136 +++++++++++++
 tb/tb_map_tile_ram.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/map_tile_ram.sv
// Tile map storage with NUM_RD registered read channels, one write port, and a
// sequential fill engine that also performs the zero fill after reset.
module map_tile_ram #(
    parameter int DATA_WIDTH = 3,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 192,
    parameter int NUM_RD     = 2,
    parameter int CW         = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    input  logic                         clr_start,
    input  logic [DATA_WIDTH-1:0]        clr_value,
    output logic                         busy,
    output logic                         done,
    output logic [CW-1:0]                tile_count
);

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(DEPTH - 1);

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [DATA_WIDTH-1:0] fill_val;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  wr_accept;
    logic                  fill_last;
    logic [DATA_WIDTH-1:0] wr_old;

    assign busy = (state == FILL);

    always_comb begin
        state_next = state;
        wr_accept  = 1'b0;
        fill_last  = 1'b0;
        wr_old     = '0;
        unique case (state)
            IDLE: begin
                // A fill request wins over a simultaneous write
                if (clr_start) begin
                    state_next = FILL;
                end else if (we && ({1'b0, wr_addr} < DEPTH_EXT)) begin
                    wr_accept = 1'b1;
                    wr_old    = mem[wr_addr];
                end
            end
            FILL: begin
                fill_last = (ptr == LAST_PTR);
                if (fill_last) begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= '0;
            fill_val   <= '0;
            tile_count <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (clr_start) begin
                        fill_val   <= clr_value;
                        ptr        <= '0;
                        tile_count <= '0;
                    end else if (wr_accept) begin
                        if (wr_old == '0 && wr_data != '0) begin
                            tile_count <= tile_count + CW'(1);
                        end else if (wr_old != '0 && wr_data == '0) begin
                            tile_count <= tile_count - CW'(1);
                        end
                    end
                end
                FILL: begin
                    ptr <= ptr + ADDR_WIDTH'(1);
                    if (fill_val != '0) begin
                        tile_count <= tile_count + CW'(1);
                    end
                    if (fill_last) begin
                        done <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Storage is never reset; the post-reset zero fill defines its contents
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == FILL) begin
                mem[ptr] <= fill_val;
            end else if (wr_accept) begin
                mem[wr_addr] <= wr_data;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        assign ra = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_data[k*DATA_WIDTH +: DATA_WIDTH] <= '0;
            end else if ({1'b0, ra} < DEPTH_EXT) begin
                rd_data[k*DATA_WIDTH +: DATA_WIDTH] <= mem[ra];
            end else begin
                rd_data[k*DATA_WIDTH +: DATA_WIDTH] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_map_tile_ram.sv
// Scoreboard bench for map_tile_ram: reads push expected data, a monitor pops
// and compares one cycle later; status outputs are checked directly.
module tb_map_tile_ram;

    localparam int DW    = 3;
    localparam int AW    = 8;
    localparam int DEPTH = 192;
    localparam int NR    = 2;
    localparam int CW    = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             we = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [DW-1:0]    wr_data = '0;
    logic [NR*AW-1:0] rd_addr = '0;
    logic [NR*DW-1:0] rd_data;
    logic             clr_start = 1'b0;
    logic [DW-1:0]    clr_value = '0;
    logic             busy;
    logic             done;
    logic [CW-1:0]    tile_count;

    int total = 0;
    int bad = 0;
    int done_pulses = 0;

    logic [NR*DW-1:0] exp_q[$];
    logic [NR*DW-1:0] exp_val;
    logic             rd_req = 1'b0;
    logic             rd_valid = 1'b0;

    always #5 clk = ~clk;

    map_tile_ram #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (DEPTH),
        .NUM_RD    (NR),
        .CW        (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .clr_start (clr_start),
        .clr_value (clr_value),
        .busy      (busy),
        .done      (done),
        .tile_count(tile_count)
    );

    always @(posedge clk) rd_valid <= rd_req;

    // Monitor: read data appears one edge after the request was presented
    always @(negedge clk) begin
        if (done === 1'b1) done_pulses++;
        if (rd_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL rd_data: got %h with no expected entry", rd_data);
            end else begin
                exp_val = exp_q.pop_front();
                if (rd_data !== exp_val)
                    begin
                        bad++;
                        $display("[TB] FAIL rd_data: got %h, expected %h", rd_data, exp_val);
                    end
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                 input logic c, input logic [DW-1:0] cv);
        we        = w;
        wr_addr   = a;
        wr_data   = d;
        clr_start = c;
        clr_value = cv;
    endtask

    task automatic issueRead(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                             input logic [DW-1:0] e0, input logic [DW-1:0] e1);
        rd_addr = {a1, a0};
        exp_q.push_back({e1, e0});
        rd_req = 1'b1;
    endtask

    task automatic doWrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
        applyStimulus(1'b1, a, d, 1'b0, '0);
        step();
        applyStimulus(1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic waitIdle(input int expected_cycles, input string name);
        int n = 0;
        while (busy === 1'b1 && n < 1000) begin
            n++;
            step();
        end
        if (n >= 1000) begin
            total++;
            bad++;
            $display("[TB] FAIL %s: busy never dropped within 1000 cycles", name);
        end else begin
            checkOutput(name, n, expected_cycles);
        end
    endtask

    initial begin
        $display("[TB] start");

        // Reset held for two edges
        step();
        step();
        checkOutput("rst_busy", 32'(busy), 1);
        checkOutput("rst_rd_data", 32'(rd_data), 0);
        checkOutput("rst_count", 32'(tile_count), 0);
        checkOutput("rst_done", 32'(done), 0);
        rst = 1'b0;
        waitIdle(DEPTH, "reset_fill_cycles");
        checkOutput("reset_done", 32'(done), 1);
        checkOutput("reset_count", 32'(tile_count), 0);
        for (int i = 0; i < DEPTH; i++) begin
            issueRead(AW'(i), AW'(DEPTH - 1 - i), '0, '0);
            step();
        end
        rd_req = 1'b0;
        checkOutput("reset_done_pulses", 32'(done_pulses), 1);

        // Count tracking on one address
        doWrite(8'd5, 3'd2);
        checkOutput("count_w2", 32'(tile_count), 1);
        doWrite(8'd5, 3'd3);
        checkOutput("count_w3", 32'(tile_count), 1);
        doWrite(8'd5, 3'd0);
        checkOutput("count_w0", 32'(tile_count), 0);

        // Read-before-write, then read-after-write on both channels
        applyStimulus(1'b1, 8'd10, 3'b101, 1'b0, '0);
        issueRead(8'd10, 8'd10, 3'd0, 3'd0);
        step();
        applyStimulus(1'b0, '0, '0, 1'b0, '0);
        issueRead(8'd10, 8'd10, 3'd5, 3'd5);
        step();
        rd_req = 1'b0;
        checkOutput("count_addr10", 32'(tile_count), 1);

        // Out-of-range write and read
        doWrite(8'd200, 3'd6);
        checkOutput("count_oob_write", 32'(tile_count), 1);
        issueRead(8'd250, 8'd10, 3'd0, 3'd5);
        step();
        issueRead(8'd200, 8'd5, 3'd0, 3'd0);
        step();
        rd_req = 1'b0;

        // Fill with 4; simultaneous write dropped, mid-fill requests ignored
        applyStimulus(1'b1, 8'd7, 3'd2, 1'b1, 3'd4);
        step();
        applyStimulus(1'b0, '0, '0, 1'b0, '0);
        checkOutput("fill_busy", 32'(busy), 1);
        checkOutput("fill_count_start", 32'(tile_count), 0);
        for (int i = 0; i < 20; i++) step();
        applyStimulus(1'b1, 8'd7, 3'd1, 1'b1, 3'd0);
        issueRead(8'd0, 8'd191, 3'd4, 3'd0);
        step();
        applyStimulus(1'b0, '0, '0, 1'b0, '0);
        rd_req = 1'b0;
        waitIdle(171, "fill_remaining_cycles");
        checkOutput("fill_done", 32'(done), 1);
        checkOutput("fill_count", 32'(tile_count), 192);
        issueRead(8'd7, 8'd100, 3'd4, 3'd4);
        step();
        checkOutput("fill_done_drop", 32'(done), 0);
        issueRead(8'd191, 8'd0, 3'd4, 3'd4);
        step();
        rd_req = 1'b0;
        checkOutput("fill_done_pulses", 32'(done_pulses), 2);

        // Reset at fill cycle 50 restarts the zero fill
        applyStimulus(1'b0, '0, '0, 1'b1, 3'd3);
        step();
        applyStimulus(1'b0, '0, '0, 1'b0, '0);
        for (int i = 0; i < 49; i++) step();
        checkOutput("midfill_count", 32'(tile_count), 49);
        rst = 1'b1;
        step();
        checkOutput("midrst_busy", 32'(busy), 1);
        checkOutput("midrst_count", 32'(tile_count), 0);
        checkOutput("midrst_rd_data", 32'(rd_data), 0);
        step();
        rst = 1'b0;
        waitIdle(DEPTH, "midrst_fill_cycles");
        checkOutput("midrst_done", 32'(done), 1);
        checkOutput("midrst_final_count", 32'(tile_count), 0);
        issueRead(8'd0, 8'd191, 3'd0, 3'd0);
        step();
        checkOutput("midrst_done_drop", 32'(done), 0);
        issueRead(8'd50, 8'd7, 3'd0, 3'd0);
        step();
        rd_req = 1'b0;
        step();

        checkOutput("scoreboard_drained", 32'(exp_q.size()), 0);
        checkOutput("total_done_pulses", 32'(done_pulses), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
